// File: rtl/dfr_sample_sequencer.sv
// Streams stored input samples one at a time through the ASIC function
// interface and writes each captured result to the output buffer.
module dfr_sample_sequencer #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   num_samples,
  input  logic [15:0]           settle_cycles,
  input  logic [15:0]           timeout_cycles,
  output logic                  in_rd_en,
  output logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_rd_data,
  output logic                  asic_start,
  output logic [DATA_WIDTH-1:0] asic_data,
  input  logic                  asic_valid,
  input  logic [DATA_WIDTH-1:0] asic_result,
  output logic                  out_wr_en,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic [ADDR_WIDTH:0]   samples_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_DRIVE, S_WAIT, S_WRITE, S_SETTLE
  } state_t;

  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                r_state, w_next;
  logic [ADDR_WIDTH:0]   r_num;
  logic [15:0]           r_settle, r_timeout, r_cnt;
  logic [ADDR_WIDTH-1:0] r_index;
  logic                  w_accept, w_abort, w_last, w_timeout_hit;

  assign w_accept      = (r_state == S_IDLE) && start && !abort;
  assign w_abort       = abort && (r_state != S_IDLE);
  assign w_last        = ({1'b0, r_index} == (r_num - ONE));
  assign w_timeout_hit = (r_timeout != '0) && ((r_cnt + 16'd1) == r_timeout);
  assign in_addr       = r_index;

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_accept && (num_samples != '0)) w_next = S_FETCH;
        S_FETCH:  w_next = S_LATCH;
        S_LATCH:  w_next = S_DRIVE;
        S_DRIVE:  w_next = S_WAIT;
        S_WAIT: begin
          if (asic_valid)         w_next = S_WRITE;
          else if (w_timeout_hit) w_next = S_IDLE;
        end
        S_WRITE: begin
          if (w_last)                w_next = S_IDLE;
          else if (r_settle != '0)   w_next = S_SETTLE;
          else                       w_next = S_FETCH;
        end
        S_SETTLE: if (r_cnt == (r_settle - 16'd1)) w_next = S_FETCH;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Strobes and busy are registered from the next state so they line up with
  // the state they belong to while an abort suppresses them the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_rd_en     <= 1'b0;
      asic_start   <= 1'b0;
      out_wr_en    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      asic_data    <= '0;
      out_addr     <= '0;
      out_wr_data  <= '0;
      samples_done <= '0;
      r_num        <= '0;
      r_settle     <= '0;
      r_timeout    <= '0;
      r_cnt        <= '0;
      r_index      <= '0;
    end else begin
      in_rd_en   <= (w_next == S_FETCH);
      asic_start <= (w_next == S_DRIVE);
      out_wr_en  <= (w_next == S_WRITE);
      busy       <= (w_next != S_IDLE);
      if (!w_abort) begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_num        <= num_samples;
              r_settle     <= settle_cycles;
              r_timeout    <= timeout_cycles;
              done         <= (num_samples == '0);
              timeout_err  <= 1'b0;
              samples_done <= '0;
              r_index      <= '0;
            end
          end
          S_LATCH: asic_data <= in_rd_data;
          S_DRIVE: r_cnt <= '0;
          S_WAIT: begin
            if (asic_valid) begin
              out_wr_data <= asic_result;
              out_addr    <= r_index;
            end else if (w_timeout_hit) begin
              timeout_err <= 1'b1;
              done        <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          S_WRITE: begin
            samples_done <= samples_done + ONE;
            r_cnt        <= '0;
            if (w_last) done    <= 1'b1;
            else        r_index <= r_index + 1'b1;
          end
          S_SETTLE: r_cnt <= r_cnt + 16'd1;
          default: ;
        endcase
      end
    end
  end

endmodule
